// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and helpers for the mp_reg_file register file.
//   - DW_DEF / DEPTH_DEF / AW_DEF     : default word width, register count, index width
//   - SP_IDX_DEF / SP_INIT_DEF        : default stack-pointer register and its reset value
//   - rf_fwd_sel_e / rf_fwd()         : same-cycle forwarding priority select, used by the
//                                       read ports when REGFILE_BYPASS_EN is defined
package rf_pkg;

    localparam int          DW_DEF      = 32;
    localparam int          DEPTH_DEF   = 32;
    localparam int          AW_DEF      = $clog2(DEPTH_DEF);
    localparam int          SP_IDX_DEF  = 29;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_0400;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_W0   = 2'd1,
        FWD_W1   = 2'd2
    } rf_fwd_sel_e;

    // The load writeback port wins over the ALU port when both hit the same register,
    // matching the array's write-collision rule.
    function automatic rf_fwd_sel_e rf_fwd(input logic hit_w0, input logic hit_w1);
        rf_fwd_sel_e sel;
        sel = FWD_NONE;
        if (hit_w1) begin
            sel = FWD_W1;
        end else if (hit_w0) begin
            sel = FWD_W0;
        end
        return sel;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of mp_reg_file.
//   Optional feature macro: REGFILE_BYPASS_EN (same-cycle write forwarding).
// Ports:
//   rd_addr  in  AW       register index to read
//   regs     in  DW x DEPTH  register array contents (pre-edge state)
//   pend     in  DEPTH    pending scoreboard (pre-edge state)
//   en, w0_*, w1_*, iss_* in  write/issue requests of the current cycle (bypass only)
//   rd_data  out DW       read data (register 0 always reads 0)
//   rd_pend  out 1        pending flag of the addressed register
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]    rd_addr,
    input  logic [DW-1:0]    regs [DEPTH],
    input  logic [DEPTH-1:0] pend,
    input  logic             en,
    input  logic             w0_en,
    input  logic [AW-1:0]    w0_addr,
    input  logic [DW-1:0]    w0_data,
    input  logic             w1_en,
    input  logic [AW-1:0]    w1_addr,
    input  logic [DW-1:0]    w1_data,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    output logic [DW-1:0]    rd_data,
    output logic             rd_pend
);

    logic          is_zero;
    logic [DW-1:0] arr_data;
    logic          arr_pend;

    assign is_zero  = (rd_addr == '0);
    assign arr_data = is_zero ? '0 : regs[rd_addr];
    assign arr_pend = is_zero ? 1'b0 : pend[rd_addr];

`ifdef REGFILE_BYPASS_EN
    logic        hit_w0;
    logic        hit_w1;
    logic        hit_iss;
    rf_fwd_sel_e fwd_sel;

    // A hit needs the same qualification as a real write, so a forwarded value is
    // always the value the array will hold after the edge.
    assign hit_w0  = en && w0_en && !is_zero && (w0_addr == rd_addr);
    assign hit_w1  = en && w1_en && !is_zero && (w1_addr == rd_addr);
    assign hit_iss = en && iss_en && !is_zero && (iss_addr == rd_addr);
    assign fwd_sel = rf_fwd(hit_w0, hit_w1);

    always_comb begin
        rd_data = arr_data;
        rd_pend = arr_pend;
        case (fwd_sel)
            FWD_W1: begin
                rd_data = w1_data;
                rd_pend = hit_iss;
            end
            FWD_W0: begin
                rd_data = w0_data;
                rd_pend = hit_iss;
            end
            default: ;
        endcase
    end
`else
    logic unused_byp;
    assign unused_byp = ^{en, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
                          iss_en, iss_addr};

    assign rd_data = arr_data;
    assign rd_pend = arr_pend;
`endif

endmodule

// File: rtl/mp_reg_file.sv
// mp_reg_file: multi-port CPU register file with two write ports, a per-register
// pending scoreboard and a debug read port.
//   Optional feature macro: REGFILE_BYPASS_EN (read ports forward same-cycle writes).
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   en                      global enable for all writes and scoreboard updates
//   w0_en/addr/data         ALU writeback port
//   w1_en/addr/data         load writeback port (wins on address collision)
//   iss_en/iss_addr         mark a register pending (result outstanding)
//   rd_addr/rd_data/rd_pend NUM_RD packed read ports, port k in slice k
//   dbg_addr/dbg_data       debug read, always the registered array value
module mp_reg_file
    import rf_pkg::*;
#(
    parameter int             DW      = DW_DEF,
    parameter int             DEPTH   = DEPTH_DEF,
    parameter int             NUM_RD  = 2,
    parameter int             SP_IDX  = SP_IDX_DEF,
    parameter logic [DW-1:0]  SP_INIT = DW'(SP_INIT_DEF)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              w0_en,
    input  logic [$clog2(DEPTH)-1:0]          w0_addr,
    input  logic [DW-1:0]                     w0_data,
    input  logic                              w1_en,
    input  logic [$clog2(DEPTH)-1:0]          w1_addr,
    input  logic [DW-1:0]                     w1_data,
    input  logic                              iss_en,
    input  logic [$clog2(DEPTH)-1:0]          iss_addr,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0]   rd_addr,
    output logic [NUM_RD*DW-1:0]              rd_data,
    output logic [NUM_RD-1:0]                 rd_pend,
    input  logic [$clog2(DEPTH)-1:0]          dbg_addr,
    output logic [DW-1:0]                     dbg_data
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DW-1:0]    regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Port 1 is applied after port 0 so a collision leaves the load value, and the
    // issue set is applied last so a new producer overrides a same-cycle write clear.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (en) begin
            if (w0_en && (w0_addr != '0)) begin
                regs_d[w0_addr] = w0_data;
                pend_d[w0_addr] = 1'b0;
            end
            if (w1_en && (w1_addr != '0)) begin
                regs_d[w1_addr] = w1_data;
                pend_d[w1_addr] = 1'b0;
            end
            if (iss_en && (iss_addr != '0)) begin
                pend_d[iss_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= ((SP_IDX != 0) && (i == SP_IDX)) ? SP_INIT : '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            rf_read_port #(
                .DW    (DW),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_rd (
                .rd_addr  (rd_addr[k*AW +: AW]),
                .regs     (regs_q),
                .pend     (pend_q),
                .en       (en),
                .w0_en    (w0_en),
                .w0_addr  (w0_addr),
                .w0_data  (w0_data),
                .w1_en    (w1_en),
                .w1_addr  (w1_addr),
                .w1_data  (w1_data),
                .iss_en   (iss_en),
                .iss_addr (iss_addr),
                .rd_data  (rd_data[k*DW +: DW]),
                .rd_pend  (rd_pend[k])
            );
        end
    endgenerate

    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_mp_reg_file.sv
// tb_mp_reg_file: directed and randomized checks of mp_reg_file against a
// behavioural array/scoreboard model. Honours REGFILE_BYPASS_EN when defined.
module tb_mp_reg_file;

    localparam int DW     = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                 clk      = 1'b0;
    logic                 rst_n    = 1'b0;
    logic                 en       = 1'b0;
    logic                 w0_en    = 1'b0;
    logic [AW-1:0]        w0_addr  = '0;
    logic [DW-1:0]        w0_data  = '0;
    logic                 w1_en    = 1'b0;
    logic [AW-1:0]        w1_addr  = '0;
    logic [DW-1:0]        w1_data  = '0;
    logic                 iss_en   = 1'b0;
    logic [AW-1:0]        iss_addr = '0;
    logic [NUM_RD*AW-1:0] rd_addr  = '0;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_pend;
    logic [AW-1:0]        dbg_addr = '0;
    logic [DW-1:0]        dbg_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] m_regs [DEPTH];
    logic          m_pend [DEPTH];

    always #5 clk = ~clk;

    mp_reg_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .w0_en    (w0_en),
        .w0_addr  (w0_addr),
        .w0_data  (w0_data),
        .w1_en    (w1_en),
        .w1_addr  (w1_addr),
        .w1_data  (w1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_pend  (rd_pend),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_regs[29] = 32'h400;
    endfunction

    function automatic void m_commit();
        if (en) begin
            if (w0_en && w0_addr != 0) begin
                m_regs[w0_addr] = w0_data;
                m_pend[w0_addr] = 1'b0;
            end
            if (w1_en && w1_addr != 0) begin
                m_regs[w1_addr] = w1_data;
                m_pend[w1_addr] = 1'b0;
            end
            if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
    endfunction

    function automatic void exp_rd(input logic [AW-1:0] a, output logic [DW-1:0] d,
                                   output logic p);
        d = (a == 0) ? '0 : m_regs[a];
        p = (a == 0) ? 1'b0 : m_pend[a];
`ifdef REGFILE_BYPASS_EN
        if (en && a != 0 && ((w0_en && w0_addr == a) || (w1_en && w1_addr == a))) begin
            d = (w1_en && w1_addr == a) ? w1_data : w0_data;
            p = iss_en && (iss_addr == a);
        end
`endif
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] ed;
        logic          ep;
        for (int k = 0; k < NUM_RD; k++) begin
            exp_rd(rd_addr[k*AW +: AW], ed, ep);
            chk($sformatf("%s_rd_data%0d", tag, k), rd_data[k*DW +: DW], ed);
            chk($sformatf("%s_rd_pend%0d", tag, k), {31'b0, rd_pend[k]}, {31'b0, ep});
        end
        chk($sformatf("%s_dbg", tag), dbg_data, m_regs[dbg_addr]);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_commit();
        #1;
    endtask

    task automatic step(input string tag);
        #1;
        check_all(tag);
        tick();
    endtask

    task automatic idle();
        en = 1'b1; w0_en = 1'b0; w1_en = 1'b0; iss_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] r4_before;
        m_reset();
        // Reset and release away from the clock edge
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;

        // 1. reset state
        dbg_addr = 5'd29; #1 chk("t1_sp", dbg_data, 32'h400);
        dbg_addr = 5'd5;  #1 chk("t1_r5", dbg_data, 32'h0);
        dbg_addr = 5'd0;  #1 chk("t1_r0", dbg_data, 32'h0);
        for (int a = 0; a < DEPTH; a += 2) begin
            rd_addr = {AW'(a + 1), AW'(a)};
            #1 chk($sformatf("t1_pend_%0d", a), {30'b0, rd_pend}, 32'h0);
        end
        @(posedge clk); #1;

        // 2. basic write and register 0
        idle();
        w0_en = 1'b1; w0_addr = 5'd3; w0_data = 32'hA5A5_A5A5; rd_addr = {5'd0, 5'd3};
        step("t2_w");
        w0_addr = 5'd0; w0_data = 32'h1;
        #1 chk("t2_r3", rd_data[31:0], 32'hA5A5_A5A5);
        step("t2_w0");
        idle(); dbg_addr = 5'd0;
        #1 chk("t2_r0", rd_data[63:32], 32'h0);
        chk("t2_r0_dbg", dbg_data, 32'h0);

        // 3. collision and enable gating
        w0_en = 1'b1; w0_addr = 5'd7; w0_data = 32'h11;
        w1_en = 1'b1; w1_addr = 5'd7; w1_data = 32'h22;
        rd_addr = {5'd7, 5'd3};
        step("t3_col");
        idle(); en = 1'b0; w0_en = 1'b1; w0_data = 32'h33; iss_en = 1'b1; iss_addr = 5'd7;
        step("t3_en0");
        idle(); dbg_addr = 5'd7;
        #1 chk("t3_r7", dbg_data, 32'h22);
        chk("t3_r7_pend", {31'b0, rd_pend[1]}, 32'h0);

        // 4. scoreboard
        iss_en = 1'b1; iss_addr = 5'd9; rd_addr = {5'd9, 5'd9};
        step("t4_iss");
        idle();
        #1 chk("t4_pend_set", {31'b0, rd_pend[0]}, 32'h1);
        w1_en = 1'b1; w1_addr = 5'd9; w1_data = 32'h55;
        step("t4_wr");
        idle();
        #1 chk("t4_pend_clr", {31'b0, rd_pend[0]}, 32'h0);
        iss_en = 1'b1; iss_addr = 5'd9; w1_en = 1'b1; w1_addr = 5'd9; w1_data = 32'h55;
        step("t4_both");
        idle(); dbg_addr = 5'd9;
        #1 chk("t4_pend_win", {31'b0, rd_pend[1]}, 32'h1);
        chk("t4_r9", dbg_data, 32'h55);

        // 5. same-cycle visibility of a write
        r4_before = m_regs[4];
        w0_en = 1'b1; w0_addr = 5'd4; w0_data = 32'h77; rd_addr = {5'd4, 5'd0}; dbg_addr = 5'd4;
`ifdef REGFILE_BYPASS_EN
        #1 chk("t5_same", rd_data[63:32], 32'h77);
`else
        #1 chk("t5_same", rd_data[63:32], r4_before);
`endif
        chk("t5_dbg_same", dbg_data, r4_before);
        tick();
        idle();
        #1 chk("t5_next", rd_data[63:32], 32'h77);

        // 6. asynchronous reset mid-operation
        w0_en = 1'b1; w0_addr = 5'd12; w0_data = 32'h99;
        step("t6_w");
        idle(); iss_en = 1'b1; iss_addr = 5'd12;
        step("t6_iss");
        idle(); rd_addr = {5'd29, 5'd12}; dbg_addr = 5'd12;
        #1 chk("t6_pend_pre", {31'b0, rd_pend[0]}, 32'h1);
        rst_n = 1'b0; m_reset();
        #1 chk("t6_pend_rst", {31'b0, rd_pend[0]}, 32'h0);
        chk("t6_r12_rst", dbg_data, 32'h0);
        chk("t6_sp_rst", rd_data[63:32], 32'h400);
        w1_en = 1'b1; w1_addr = 5'd12; w1_data = 32'h1234; iss_en = 1'b1;
        tick();
        #1 chk("t6_r12_held", dbg_data, 32'h0);
        idle(); rd_addr = {5'd12, 5'd12};
        #1 chk("t6_pend_held", {31'b0, rd_pend[1]}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            en       = ($urandom_range(0, 7) != 0);
            w0_en    = $urandom_range(0, 1) == 1;
            w1_en    = $urandom_range(0, 2) == 0;
            iss_en   = $urandom_range(0, 2) == 0;
            w0_addr  = AW'($urandom_range(0, 7));
            w1_addr  = ($urandom_range(0, 3) == 0) ? w0_addr : AW'($urandom_range(0, 31));
            iss_addr = ($urandom_range(0, 3) == 0) ? w1_addr : AW'($urandom_range(0, 7));
            w0_data  = $urandom;
            w1_data  = $urandom;
            for (int k = 0; k < NUM_RD; k++) begin
                case ($urandom_range(0, 3))
                    0:       rd_addr[k*AW +: AW] = w0_addr;
                    1:       rd_addr[k*AW +: AW] = w1_addr;
                    2:       rd_addr[k*AW +: AW] = iss_addr;
                    default: rd_addr[k*AW +: AW] = AW'($urandom_range(0, 31));
                endcase
            end
            dbg_addr = AW'($urandom_range(0, 31));
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
